// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad responder: queues key indices, answers the scanner's
// column strobe by pulling the matching row low, then releases on ack.
module keypad_emulator #(
    parameter int FIFO_DEPTH     = 8,
    parameter int HOLD_CYCLES    = 4,
    parameter int RELEASE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic                          key_valid,
    input  logic [3:0]                    key_index,
    output logic                          key_ready,
    input  logic [3:0]                    ColOut,
    input  logic                          key_ack,
    output logic [3:0]                    RowIn,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timeout_err
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int M1   = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
    localparam int CMAX = (TIMEOUT_CYCLES > M1) ? TIMEOUT_CYCLES : M1;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_COL,
        PRESS,
        WAIT_ACK,
        RELEASE
    } state_t;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    head;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [3:0]    row_n;
    logic [1:0]    cur_row;
    logic [1:0]    cur_col;
    logic [3:0]    col_match;
    logic          tmo_hit;
    logic          load;
    logic          abort;

    // key_ready comes only from the registered count
    assign key_ready = (fifo_count != CNTW'(FIFO_DEPTH));
    assign push      = key_valid & key_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) | (fifo_count != '0);
    assign col_match = ~(4'b0001 << cur_col);
    assign tmo_hit   = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= key_index;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        row_n   = RowIn;
        load    = 1'b0;
        pop     = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (fifo_count != '0) begin
                    state_n = WAIT_COL;
                    load    = 1'b1;
                end
            end
            WAIT_COL: begin
                // col_match is one-cold, so malformed strobes never match
                if (ColOut == col_match) begin
                    state_n = PRESS;
                    cnt_n   = '0;
                    row_n   = ~(4'b0001 << cur_row);
                end else if (tmo_hit) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                    row_n   = 4'hF;
                    abort   = 1'b1;
                end
            end
            PRESS: begin
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    state_n = WAIT_ACK;
                    cnt_n   = '0;
                end
            end
            WAIT_ACK: begin
                if (key_ack) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                    row_n   = 4'hF;
                end else if (tmo_hit) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                    row_n   = 4'hF;
                    abort   = 1'b1;
                end
            end
            RELEASE: begin
                row_n = 4'hF;
                if (cnt == CW'(RELEASE_CYCLES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    pop     = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                row_n   = 4'hF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            RowIn       <= 4'hF;
            cur_row     <= '0;
            cur_col     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            RowIn <= row_n;
            if (load) begin
                cur_row <= head[3:2];
                cur_col <= head[1:0];
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
